// File: rtl/shift_unit_arbiter.sv
// Shares one external logical barrel shifter between two requesters.
// Arbitrates, registers shifter operands, adds arithmetic sign fill, returns result over valid/ready.
//
// state | meaning
// IDLE  | waiting for a request; winner gets rq_ready
// EXEC  | shifter settling; result captured at end of cycle
// RESP  | rs_valid toward owner until rs_ready[owner]
module shift_unit_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rq_valid,
  output logic [1:0]        rq_ready,
  input  logic [DATA_W-1:0] rq_data0,
  input  logic [DATA_W-1:0] rq_data1,
  input  logic [4:0]        rq_shamt0,
  input  logic [4:0]        rq_shamt1,
  input  logic [1:0]        rq_dir,
  input  logic [1:0]        rq_arith,
  output logic [1:0]        rs_valid,
  input  logic [1:0]        rs_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] sh_a,
  output logic [4:0]        sh_n,
  output logic              sh_dir,
  input  logic [DATA_W-1:0] sh_result,
  output logic              busy
);

  if (DATA_W != 32) begin : g_bad_width
    $error("shift_unit_arbiter: DATA_W must be 32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q, prio_d;
  logic              arith_q, arith_d;
  logic [DATA_W-1:0] sh_a_q, sh_a_d;
  logic [4:0]        sh_n_q, sh_n_d;
  logic              sh_dir_q, sh_dir_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic              win;
  logic [DATA_W-1:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      arith_q   <= 1'b0;
      sh_a_q    <= '0;
      sh_n_q    <= '0;
      sh_dir_q  <= 1'b0;
      rs_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      arith_q   <= arith_d;
      sh_a_q    <= sh_a_d;
      sh_n_q    <= sh_n_d;
      sh_dir_q  <= sh_dir_d;
      rs_data_q <= rs_data_d;
    end
  end

  // prio_q names the requester favoured on the next collision.
  always_comb begin
    if (rq_valid[0] && rq_valid[1]) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
    end else begin
      win = rq_valid[1];
    end
  end

  // Shifter is logical only; sign fill covers the top sh_n bits.
  assign fill = (arith_q && sh_a_q[DATA_W-1]) ? ~({DATA_W{1'b1}} >> sh_n_q) : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    arith_d   = arith_q;
    sh_a_d    = sh_a_q;
    sh_n_d    = sh_n_q;
    sh_dir_d  = sh_dir_q;
    rs_data_d = rs_data_q;
    rq_ready  = 2'b00;
    rs_valid  = 2'b00;
    case (state_q)
      IDLE: begin
        if (|rq_valid) begin
          rq_ready[win] = 1'b1;
          owner_d       = win;
          sh_a_d        = win ? rq_data1 : rq_data0;
          sh_n_d        = win ? rq_shamt1 : rq_shamt0;
          sh_dir_d      = rq_dir[win];
          arith_d       = rq_arith[win] & ~rq_dir[win];
          state_d       = EXEC;
        end
      end
      EXEC: begin
        rs_data_d = sh_result | fill;
        state_d   = RESP;
      end
      RESP: begin
        rs_valid[owner_q] = 1'b1;
        if (rs_ready[owner_q]) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rs_data = rs_data_q;
  assign sh_a    = sh_a_q;
  assign sh_n    = sh_n_q;
  assign sh_dir  = sh_dir_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus; each drives a behavioural shifter.
module tb_shift_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rq_valid = 2'b00;
  logic [31:0] rq_data0 = '0, rq_data1 = '0;
  logic [4:0]  rq_shamt0 = '0, rq_shamt1 = '0;
  logic [1:0]  rq_dir = 2'b00, rq_arith = 2'b00;
  logic [1:0]  rs_ready = 2'b00;

  logic [1:0]  rq_ready, rs_valid, rq_ready_f, rs_valid_f;
  logic [31:0] rs_data, sh_a, sh_result, rs_data_f, sh_a_f, sh_result_f;
  logic [4:0]  sh_n, sh_n_f;
  logic        sh_dir, busy, sh_dir_f, busy_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sh_result   = sh_dir ? (sh_a << sh_n) : (sh_a >> sh_n);
  assign sh_result_f = sh_dir_f ? (sh_a_f << sh_n_f) : (sh_a_f >> sh_n_f);

  shift_unit_arbiter #(.FIXED_PRIO(0), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_data0(rq_data0), .rq_data1(rq_data1), .rq_shamt0(rq_shamt0), .rq_shamt1(rq_shamt1),
    .rq_dir(rq_dir), .rq_arith(rq_arith), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_data(rs_data), .sh_a(sh_a), .sh_n(sh_n), .sh_dir(sh_dir),
    .sh_result(sh_result), .busy(busy)
  );

  shift_unit_arbiter #(.FIXED_PRIO(1), .DATA_W(32)) dut_f (
    .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready_f),
    .rq_data0(rq_data0), .rq_data1(rq_data1), .rq_shamt0(rq_shamt0), .rq_shamt1(rq_shamt1),
    .rq_dir(rq_dir), .rq_arith(rq_arith), .rs_valid(rs_valid_f), .rs_ready(rs_ready),
    .rs_data(rs_data_f), .sh_a(sh_a_f), .sh_n(sh_n_f), .sh_dir(sh_dir_f),
    .sh_result(sh_result_f), .busy(busy_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rq_ready"}, {30'd0, rq_ready}, 32'd0);
    check({tag, "_rs_valid"}, {30'd0, rs_valid}, 32'd0);
    check({tag, "_rs_data"}, rs_data, 32'd0);
    check({tag, "_sh_a"}, sh_a, 32'd0);
    check({tag, "_sh_n"}, {27'd0, sh_n}, 32'd0);
    check({tag, "_sh_dir"}, {31'd0, sh_dir}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE; returns likewise.
  task automatic do_op(input string tag, input int idx, input logic [31:0] data,
                       input logic [4:0] shamt, input logic dir, input logic arith,
                       input logic [31:0] exp);
    logic [1:0] sel;
    sel = (idx == 0) ? 2'b01 : 2'b10;
    if (idx == 0) begin
      rq_data0 = data; rq_shamt0 = shamt;
    end else begin
      rq_data1 = data; rq_shamt1 = shamt;
    end
    rq_dir   = dir ? sel : 2'b00;
    rq_arith = arith ? sel : 2'b00;
    rq_valid = sel;
    rs_ready = 2'b00;
    #1;
    check({tag, "_rq_ready"}, {30'd0, rq_ready}, {30'd0, sel});
    @(posedge clk); #1;
    rq_valid = 2'b00;
    check({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_exec_rs_valid"}, {30'd0, rs_valid}, 32'd0);
    check({tag, "_sh_a"}, sh_a, data);
    check({tag, "_sh_n"}, {27'd0, sh_n}, {27'd0, shamt});
    @(posedge clk); #1;
    check({tag, "_rs_valid"}, {30'd0, rs_valid}, {30'd0, sel});
    check({tag, "_rs_data"}, rs_data, exp);
    rs_ready = sel;
    @(posedge clk); #1;
    rs_ready = 2'b00;
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_g;
    logic [31:0] held;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous collision: round-robin alternates from 0, fixed priority always 0.
    rq_data0 = 32'h0000_00FF; rq_shamt0 = 5'd4;
    rq_data1 = 32'hF000_0000; rq_shamt1 = 5'd8;
    rq_dir = 2'b01; rq_arith = 2'b10;
    rq_valid = 2'b11; rs_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (rq_ready == 2'b00 && n < 8) begin
        @(posedge clk); #1; n++;
      end
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_grant", {30'd0, rq_ready}, {30'd0, exp_g});
      check("fixed_grant", {30'd0, rq_ready_f}, 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rr_rs_valid", {30'd0, rs_valid}, {30'd0, exp_g});
      check("rr_rs_data", rs_data, (k % 2 == 0) ? 32'h0000_0FF0 : 32'hFFF0_0000);
      check("fixed_rs_data", rs_data_f, 32'h0000_0FF0);
      if (k == 3) rq_valid = 2'b00;
      @(posedge clk); #1;
    end
    rs_ready = 2'b00;
    check("rr_end_busy", {31'd0, busy}, 32'd0);

    do_op("shr",      0, 32'h8000_00F0, 5'd4,  1'b0, 1'b0, 32'h0800_000F);
    do_op("sar4",     1, 32'h8000_00F0, 5'd4,  1'b0, 1'b1, 32'hF800_000F);
    do_op("sar0",     1, 32'h8000_00F0, 5'd0,  1'b0, 1'b1, 32'h8000_00F0);
    do_op("sar31",    1, 32'h8000_00F0, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF);
    do_op("shl_arith",0, 32'h0000_0001, 5'd31, 1'b1, 1'b1, 32'h8000_0000);

    // Back-pressure on owner 0; non-owner rs_ready and new requests must be ignored.
    rq_data0 = 32'h8000_00F0; rq_shamt0 = 5'd4; rq_dir = 2'b00; rq_arith = 2'b01;
    rq_valid = 2'b01;
    @(posedge clk); #1;
    rq_valid = 2'b00;
    @(posedge clk); #1;
    held = 32'hF800_000F;
    rq_valid = 2'b11; rs_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rs_valid", {30'd0, rs_valid}, 32'd1);
      check("bp_rs_data", rs_data, held);
      check("bp_rq_ready", {30'd0, rq_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    rq_valid = 2'b00; rs_ready = 2'b01;
    @(posedge clk); #1;
    rs_ready = 2'b00;
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_release_rs_valid", {30'd0, rs_valid}, 32'd0);

    // Reset during EXEC drops the transaction.
    rq_data1 = 32'h1234_5678; rq_shamt1 = 5'd8; rq_dir = 2'b10; rq_arith = 2'b00;
    rq_valid = 2'b10;
    @(posedge clk); #1;
    rq_valid = 2'b00;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", {30'd0, rs_valid}, 32'd0);
    end
    do_op("post_rst", 1, 32'h1234_5678, 5'd4, 1'b1, 1'b0, 32'h2345_6780);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
